drum_event_spi_slave: RTL and testbench
=======================================

// Module: drum_event_spi_slave
// PURPOSE
//  Consumer end of the drum trigger interface. Captures each drum_trigger_valid
//  rising edge (code + hand), queues events in a small FIFO, and serves them to
//  the MCU, which acts as SPI master (mode 0, MSB first), one 8-bit frame per
//  chip-select assertion. Sits between the trigger processor and the top-level
//  SPI pins.
// PARAMETERS
//  FIFO_DEPTH   8   event entries; power of two, >= 2
//  SYNC_STAGES  2   flip-flop synchroniser depth for sck and cs_n
// PORTS
//  clk                 in   1  system clock; all logic in this domain
//  rst                 in   1  synchronous, active-high reset
//  drum_trigger_valid  in   1  level; held >= 1 cycle per event
//  drum_code           in   4  drum code 0-7 (bit 3 reserved, stored as given)
//  drum_hand           in   1  0 = right, 1 = left
//  sck                 in   1  SPI clock from MCU (async; synchronised)
//  cs_n                in   1  SPI chip select, active low (async; synchronised)
//  sdo                 out  1  SPI data to MCU (MISO)
//  fifo_level          out  $clog2(FIFO_DEPTH)+1  current entry count (debug)
//  overflow            out  1  sticky overflow flag
// BEHAVIOUR
//  Reset: sdo=0, fifo_level=0, overflow=0, FIFO empty, FSM=IDLE, shift reg=0,
//   bit_cnt=0, valid edge detector primed to 1 (a valid held high through
//   reset does not push).
//  Capture: push {hand,code} exactly once per 0->1 edge of drum_trigger_valid,
//   on the cycle after the edge (1-cycle latency). Re-asserting valid while
//   still high never re-pushes.
//  Full: a push while full is dropped and sets overflow. When full, push and
//   pop in the same cycle both take effect: the event is stored, level is
//   unchanged, and overflow is not set.
//  Sync: sck and cs_n pass through SYNC_STAGES flops plus a registered edge
//   detect. Requires f_sck <= f_clk/8.
//  Frame bits: [7] valid (FIFO non-empty at load), [6] overflow, [5] hand,
//   [4] 0, [3:0] code. When FIFO is empty, bits 5:0 = 0.
//  FSM:
//   IDLE -> LOAD on synchronised cs_n fall.
//   LOAD (1 cycle): shift_reg <= frame; sdo <= frame[7]; bit_cnt <= 0; -> SHIFT.
//   SHIFT: on each sck rise, bit_cnt++. On each sck fall with bit_cnt < 8,
//    shift left; sdo <= next MSB. After 8 bits, sdo holds 0.
//    -> IDLE on cs_n rise.
//   End of frame (cs_n rise): if bit_cnt == 8 and frame[7] = 1, pop the head.
//    If bit_cnt == 8, clear overflow when frame[6] = 1, unless a new overflow
//    occurs in the same cycle (set wins). Otherwise (aborted frame, bit_cnt < 8):
//    no pop, overflow kept, same event re-served next frame.
//  Head stability: the frame is snapshotted at LOAD. Pushes during a frame do
//   not alter the bits being shifted out.
//  sdo = 0 whenever FSM is IDLE. There is no tristate; the top level gates the
//   pin with cs_n.
//  sck edges while cs_n is high are ignored. Extra sck edges beyond 8 bits are
//   ignored (bit_cnt saturates at 8).
//  Reset mid-frame: immediate return to IDLE and FIFO flush; the MCU sees
//   sdo = 0 for the rest of the frame.
// STRUCTURE
//  drum_pkg (shared): typedef struct packed {logic hand; logic [3:0] code;}
//   drum_event_t; localparams FRAME_BITS=8 and FRM_VALID=7, FRM_OVF=6,
//   FRM_HAND=5; typedef enum {IDLE, LOAD, SHIFT} spi_tx_state_t.
//  Sub-module: drum_event_fifo (synchronous FIFO of drum_event_t, push/pop/
//   full/empty/level, simultaneous push+pop when full allowed). Synchroniser,
//   edge detect, FSM and shifter stay in this module.
// TESTING
//  1 trigger code=5 hand=1 held 5 cycles, then one frame -> MISO 0xA5;
//    level 1->0; only one push.
//  2 frame with FIFO empty -> 0x00; level stays 0; no pop.
//  3 nine triggers (DEPTH 8), no reads -> level 8, overflow=1; first frame has
//    bit6 set, then overflow=0; 8 frames drain in order, 9th frame = 0x00.
//  4 trigger code=3 hand=0; frame aborted after 4 sck -> no pop; next full
//    frame -> 0x83, then empty.
//  5 FIFO full; trigger edge on the same cycle as the end-of-frame pop ->
//    level stays 8, overflow stays 0, new event is last out.
//  6 rst asserted mid-frame after 3 bits -> sdo=0, level=0, FSM IDLE; next
//    frame -> 0x00.

Source files
------------

// File: rtl/drum_pkg.sv
// drum_pkg: shared event type, SPI frame layout and transmitter states
// for the drum event SPI slave.
package drum_pkg;

    typedef struct packed {
        logic       hand;
        logic [3:0] code;
    } drum_event_t;

    localparam int FRAME_BITS = 8;
    localparam int FRM_VALID  = 7;
    localparam int FRM_OVF    = 6;
    localparam int FRM_HAND   = 5;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} spi_tx_state_t;

    // An empty FIFO still reports the overflow flag, but the payload bits read as zero.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic vld, input logic ovf,
                                                         input drum_event_t ev);
        logic [FRAME_BITS-1:0] f;
        f            = '0;
        f[FRM_VALID] = vld;
        f[FRM_OVF]   = ovf;
        if (vld) begin
            f[FRM_HAND] = ev.hand;
            f[3:0]      = ev.code;
        end
        return f;
    endfunction

endpackage

// File: rtl/drum_event_fifo.sv
// drum_event_fifo: synchronous FIFO of drum events.
// Ports: clk, rst (sync, active high); push/din write an event; pop retires the head;
// dout is the current head; full/empty/level report occupancy.
// A push while full is accepted only when a pop happens in the same cycle.
module drum_event_fifo
    import drum_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  drum_event_t               din,
    output drum_event_t               dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    drum_event_t    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            level  <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/drum_event_spi_slave.sv
// drum_event_spi_slave: captures drum trigger events into a FIFO and serves them
// to an SPI master (mode 0, MSB first), one 8-bit frame per chip-select assertion.
// Ports: clk, rst (sync, active high); drum_trigger_valid/drum_code/drum_hand event input;
// sck, cs_n asynchronous SPI inputs; sdo MISO data; fifo_level debug count;
// overflow sticky flag set by a dropped event, cleared by a completed frame that reported it.
module drum_event_spi_slave
    import drum_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          drum_trigger_valid,
    input  logic [3:0]                    drum_code,
    input  logic                          drum_hand,
    input  logic                          sck,
    input  logic                          cs_n,
    output logic                          sdo,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    logic                    valid_q;
    logic                    push_r;
    drum_event_t             ev_r;
    drum_event_t             head;
    logic                    full;
    logic                    empty;
    logic                    pop;
    logic                    frame_done;
    logic [SYNC_STAGES-1:0]  sck_s;
    logic [SYNC_STAGES-1:0]  cs_s;
    logic                    sck_d;
    logic                    cs_d;
    logic                    sck_rise;
    logic                    sck_fall;
    logic                    cs_rise;
    logic                    cs_fall;
    spi_tx_state_t           state;
    logic [FRAME_BITS-2:0]   shift_reg;
    logic [3:0]              bit_cnt;
    logic                    frm_valid;
    logic                    frm_ovf;
    logic [FRAME_BITS-1:0]   frame;

    // valid_q resets high so a trigger held through reset is not seen as a new edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b1;
            push_r  <= 1'b0;
            ev_r    <= '0;
        end else begin
            valid_q <= drum_trigger_valid;
            push_r  <= drum_trigger_valid & ~valid_q;
            ev_r    <= '{hand: drum_hand, code: drum_code};
        end
    end

    drum_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_r),
        .pop   (pop),
        .din   (ev_r),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // cs_n chain resets low so a frame in progress at reset is not re-detected as a new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s <= '0;
            cs_s  <= '0;
            sck_d <= 1'b0;
            cs_d  <= 1'b0;
        end else begin
            sck_s <= {sck_s[SYNC_STAGES-2:0], sck};
            cs_s  <= {cs_s[SYNC_STAGES-2:0], cs_n};
            sck_d <= sck_s[SYNC_STAGES-1];
            cs_d  <= cs_s[SYNC_STAGES-1];
        end
    end

    assign sck_rise   = sck_s[SYNC_STAGES-1] & ~sck_d;
    assign sck_fall   = ~sck_s[SYNC_STAGES-1] & sck_d;
    assign cs_rise    = cs_s[SYNC_STAGES-1] & ~cs_d;
    assign cs_fall    = ~cs_s[SYNC_STAGES-1] & cs_d;
    assign frame      = make_frame(~empty, overflow, head);
    assign frame_done = (state == SHIFT) && cs_rise && (bit_cnt == 4'(FRAME_BITS));
    assign pop        = frame_done & frm_valid;

    // A drop needs the FIFO still full after this cycle's pop; a new drop beats the clear.
    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else
            overflow <= (push_r & full & ~pop) ? 1'b1 : (frame_done & frm_ovf) ? 1'b0 : overflow;
    end

    // The MSB goes out at LOAD; shift_reg holds the remaining seven bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sdo       <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            frm_valid <= 1'b0;
            frm_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sdo   <= 1'b0;
                    state <= cs_fall ? LOAD : IDLE;
                end
                LOAD: begin
                    shift_reg <= frame[FRAME_BITS-2:0];
                    sdo       <= frame[FRM_VALID];
                    frm_valid <= frame[FRM_VALID];
                    frm_ovf   <= frame[FRM_OVF];
                    bit_cnt   <= '0;
                    state     <= cs_rise ? IDLE : SHIFT;
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state <= IDLE;
                        sdo   <= 1'b0;
                    end else begin
                        if (sck_rise && bit_cnt < 4'(FRAME_BITS))
                            bit_cnt <= bit_cnt + 1'b1;
                        if (sck_fall) begin
                            sdo       <= (bit_cnt < 4'(FRAME_BITS)) ? shift_reg[FRAME_BITS-2] : 1'b0;
                            shift_reg <= (bit_cnt < 4'(FRAME_BITS)) ? {shift_reg[FRAME_BITS-3:0], 1'b0}
                                                                    : shift_reg;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drum_event_spi_slave.sv
// tb_drum_event_spi_slave: scoreboard bench; an event-queue reference model predicts
// each frame, and a monitor on the SPI pins compares completed frames.
module tb_drum_event_spi_slave;
    logic       clk = 1'b0;
    logic       rst;
    logic       drum_trigger_valid;
    logic [3:0] drum_code;
    logic       drum_hand;
    logic       sck;
    logic       cs_n;
    logic       sdo;
    logic [3:0] fifo_level;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    logic [4:0] mq[$];
    bit         movf;
    logic [7:0] exp_q[$];

    drum_event_spi_slave dut (
        .clk                (clk),
        .rst                (rst),
        .drum_trigger_valid (drum_trigger_valid),
        .drum_code          (drum_code),
        .drum_hand          (drum_hand),
        .sck                (sck),
        .cs_n               (cs_n),
        .sdo                (sdo),
        .fifo_level         (fifo_level),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic void mpush(input logic [3:0] c, input logic h);
        if (mq.size() < 8)
            mq.push_back({h, c});
        else
            movf = 1'b1;
    endfunction

    function automatic logic [7:0] model_frame();
        if (mq.size() == 0)
            return {1'b0, movf, 6'd0};
        return {1'b1, movf, mq[0][4], 1'b0, mq[0][3:0]};
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_level"}, int'(fifo_level), mq.size());
        chk({tag, "_overflow"}, int'(overflow), int'(movf));
    endtask

    task automatic trig(input logic [3:0] c, input logic h, input int hold);
        @(negedge clk);
        drum_code          = c;
        drum_hand          = h;
        drum_trigger_valid = 1'b1;
        repeat (hold) @(negedge clk);
        drum_trigger_valid = 1'b0;
        repeat (2) @(negedge clk);
        mpush(c, h);
    endtask

    task automatic sck_bits(input int n);
        for (int i = 0; i < n; i++) begin
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic frame(input int nbits, input bit inj, input logic [3:0] ic, input logic ih);
        logic [7:0] e;
        e = model_frame();
        if (nbits >= 8)
            exp_q.push_back(e);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        sck_bits(nbits);
        cs_n = 1'b1;
        if (inj) begin
            @(negedge clk);
            drum_code          = ic;
            drum_hand          = ih;
            drum_trigger_valid = 1'b1;
            @(negedge clk);
            drum_trigger_valid = 1'b0;
        end
        if (nbits >= 8) begin
            if (e[7])
                void'(mq.pop_front());
            if (e[6])
                movf = 1'b0;
        end
        if (inj)
            mpush(ic, ih);
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mq.delete();
        movf = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int nb;
        bit ab;
        bit done;
        logic [7:0] rx;
        forever begin
            @(negedge cs_n);
            nb   = 0;
            ab   = 1'b0;
            done = 1'b0;
            rx   = '0;
            while (!done) begin
                @(posedge sck or posedge cs_n or posedge rst);
                if (cs_n)
                    done = 1'b1;
                else if (rst)
                    ab = 1'b1;
                else begin
                    if (nb < 8)
                        rx = {rx[6:0], sdo};
                    nb++;
                end
            end
            if (!ab && nb >= 8) begin
                if (exp_q.size() == 0)
                    chk("frame_unexpected", int'(rx), -1);
                else
                    chk("frame", int'(rx), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst                = 1'b1;
        drum_trigger_valid = 1'b1;
        drum_code          = 4'd0;
        drum_hand          = 1'b0;
        sck                = 1'b0;
        cs_n               = 1'b1;
        movf               = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_sdo", int'(sdo), 0);
        check_state("reset");
        repeat (3) @(negedge clk);
        chk("held_valid_no_push", int'(fifo_level), 0);
        drum_trigger_valid = 1'b0;
        repeat (3) @(negedge clk);

        trig(4'd5, 1'b1, 5);
        check_state("single_push");
        frame(8, 1'b0, 4'd0, 1'b0);
        check_state("after_a5");

        frame(8, 1'b0, 4'd0, 1'b0);
        check_state("empty_frame");

        for (int i = 0; i < 9; i++)
            trig(4'(i), 1'(i), 1);
        check_state("fill9");
        frame(8, 1'b0, 4'd0, 1'b0);
        check_state("ovf_reported");
        for (int i = 0; i < 8; i++)
            frame(8, 1'b0, 4'd0, 1'b0);
        check_state("drained");

        trig(4'd3, 1'b0, 2);
        frame(4, 1'b0, 4'd0, 1'b0);
        check_state("aborted");
        frame(8, 1'b0, 4'd0, 1'b0);
        frame(8, 1'b0, 4'd0, 1'b0);
        check_state("after_83");

        do_reset();
        for (int i = 0; i < 8; i++)
            trig(4'(i + 8), 1'(~i), 1);
        check_state("full8");
        frame(8, 1'b1, 4'hE, 1'b1);
        check_state("push_pop_full");
        for (int i = 0; i < 8; i++)
            frame(8, 1'b0, 4'd0, 1'b0);
        check_state("drain_full");

        trig(4'd7, 1'b1, 1);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        sck_bits(3);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq.delete();
        movf = 1'b0;
        @(negedge clk);
        chk("midframe_rst_sdo", int'(sdo), 0);
        check_state("midframe_rst");
        for (int i = 0; i < 5; i++) begin
            sck = 1'b1;
            chk("midframe_rst_sdo_bit", int'(sdo), 0);
            repeat (4) @(negedge clk);
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        frame(8, 1'b0, 4'd0, 1'b0);
        check_state("after_rst_frame");

        for (int k = 0; k < 80; k++) begin
            int op;
            op = $urandom_range(0, 7);
            if (op < 4)
                trig(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom_range(1, 4));
            else if (op < 7)
                frame(8 + $urandom_range(0, 2), 1'b0, 4'd0, 1'b0);
            else
                frame($urandom_range(0, 7), 1'b0, 4'd0, 1'b0);
            check_state("random");
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
